instr_cache: RTL and testbench
==============================

# instr_cache

Direct-mapped instruction cache that answers the CPU's instruction fetches: it takes the CPU's `PC`, returns the 32-bit `INSTRUCTION`, and stalls the CPU with `busywait` on a miss. Misses are refilled from a 1 KiB backing instruction memory over a 128-bit block-read handshake. It sits between `cpu` and the instruction memory, taking the place of the flat combinational fetch array.

## Interface
Parameters:
- `BLOCKS`, 8: number of cache lines; drives the index width (3 bits).
- `WORDS`, 4: 32-bit words per line (16 bytes); drives the offset width (2 bits).

Ports:
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `PC`  in  32  fetch byte address from the CPU. Only `PC[9:0]` is used and `PC[1:0]` is ignored.
- `INSTRUCTION`  out  32  fetched instruction.
- `busywait`  out  1  stall request to the CPU; the CPU holds `PC` while this is high.
- `mem_read`  out  1  block read request to instruction memory.
- `mem_address`  out  6  block address, equal to {tag, index}.
- `mem_readdata`  in  128  refill block. Word w is bits [32w+31:32w]; word 0 is at the lowest address.
- `mem_busywait`  in  1  memory busy; the block is valid on the first rising edge where this is sampled 0 while `mem_read` is 1.

## Operation
- Address split:
  - offset = `PC[3:2]`
  - index = `PC[6:4]`
  - tag = `PC[9:7]`
  - Arrays: data 8×128, tag 8×3, valid 8×1.
- Hit condition: `valid[index]` is set and `tag[index]` equals the PC tag.
- On a hit, `INSTRUCTION` is the selected 32-bit word of the line.
- FSM states: IDLE, MEM_READ, UPDATE.
- IDLE:
  - Hit: `busywait` = 0. Stay in IDLE.
  - Miss: `busywait` = 1 (combinational, same cycle). Latch {tag, index} into the request register. Go to MEM_READ.
- MEM_READ:
  - `mem_read` = 1, `mem_address` = latched {tag, index}, `busywait` = 1.
  - Stay while `mem_busywait` is 1.
  - When `mem_busywait` is sampled 0, capture `mem_readdata` and go to UPDATE.
- UPDATE:
  - `mem_read` = 0, `busywait` = 1.
  - Write data, tag and valid=1 into the latched index. Go to IDLE.
- Back in IDLE, the held `PC` hits and `busywait` drops in the same cycle.
- Only the latched request address drives the refill. `PC` changes during MEM_READ/UPDATE are ignored (CPU contract violation; no corruption is allowed).
- Reset (`RESET` = 0, at any time, including mid-refill):
  - All valid bits clear; state goes to IDLE.
  - `mem_read` = 0, `mem_address` = 0, `busywait` = 0, `INSTRUCTION` = 0.
  - A pending refill is abandoned and no line is written.
  - Data and tag arrays need not be cleared.
- Reset release: the first fetch is a cold miss.
- `INSTRUCTION` holds its last hit value while `busywait` = 1.

## Timing
- Hit latency: 0 cycles. `INSTRUCTION` is combinational from `PC` and the arrays, and valid before the next rising edge.
- Miss penalty: `busywait` high for N+2 cycles, where N is the number of cycles `mem_busywait` stays high after `mem_read` rises.
- Zero-latency memory (`mem_busywait` never 1) gives exactly 2 stall cycles.
- `mem_read` rises on the first edge after the miss is detected. It falls on the edge that leaves MEM_READ.
- `mem_address` is stable for the whole time `mem_read` = 1.
- Back-to-back misses: UPDATE returns to IDLE, and a new miss is flagged in that same IDLE cycle. There are no idle bubbles beyond the one IDLE cycle.
- Conflict eviction (same index, different tag) overwrites the line unconditionally. There is no write-back.
- `PC[31:10]` nonzero aliases into the 1 KiB space without error.

## Test plan
- Cold miss after reset:
  - Stimulus: release `RESET`, `PC` = 0, memory block 0 = {0x0000_0009, 0x0002_0009, 0x0004_0005, 0x0000_0005} (word 3 to word 0), `mem_busywait` high 5 cycles.
  - Required: `mem_read` = 1 with `mem_address` = 0, `busywait` high for 7 cycles, then `INSTRUCTION` = 0x0000_0005.
- Sequential hits:
  - Stimulus: `PC` = 4, 8, 12 after the cold fill.
  - Required: `busywait` stays 0 and `INSTRUCTION` = 0x0004_0005, 0x0002_0009, 0x0000_0009, each valid within the same cycle.
- Conflict eviction:
  - Stimulus: fetch `PC` = 0x080 (index 0, tag 1), then `PC` = 0x000.
  - Required: two misses with `mem_address` = 0x08, then 0x00. The second fetch returns the original block-0 word.
- Zero-wait memory:
  - Stimulus: `mem_busywait` tied 0, miss on `PC` = 0x3F0.
  - Required: `mem_address` = 0x3F and `busywait` high exactly 2 cycles.
- Reset mid-refill:
  - Stimulus: assert `RESET` = 0 asynchronously during MEM_READ.
  - Required: `mem_read` and `busywait` drop immediately, without waiting for a clock edge. After release, the same `PC` misses again.
- PC wobble during stall:
  - Stimulus: change `PC` from 0x010 to 0x020 during MEM_READ.
  - Required: the refill still targets `mem_address` = 0x01 and line 1 only. Line 2 stays invalid.

Source files
------------

// File: rtl/instr_cache.sv
// Direct-mapped instruction cache between the CPU fetch port and a 1 KiB
// instruction memory; misses stall the CPU and refill a whole 128-bit line.
module instr_cache #(
  parameter int BLOCKS = 8,
  parameter int WORDS  = 4
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [31:0]                  PC,
  output logic [31:0]                  INSTRUCTION,
  output logic                         busywait,
  output logic                         mem_read,
  output logic [7-$clog2(WORDS):0]     mem_address,
  input  logic [32*WORDS-1:0]          mem_readdata,
  input  logic                         mem_busywait
);

  localparam int IW = $clog2(BLOCKS);
  localparam int OW = $clog2(WORDS);
  localparam int TW = 8 - IW - OW;
  localparam int AW = TW + IW;
  localparam int LW = 32 * WORDS;

  // Handshake: the refill block is taken on the first rising edge where
  // mem_read is 1 and mem_busywait is 0; mem_address is held for that whole time.
  typedef enum logic [1:0] {S_IDLE, S_MEM_READ, S_UPDATE} state_t;

  state_t          state;
  logic [LW-1:0]   data_arr [BLOCKS];
  logic [TW-1:0]   tag_arr  [BLOCKS];
  logic [BLOCKS-1:0] valid;
  logic [LW-1:0]   line_buf;
  logic [AW-1:0]   req;
  logic [31:0]     last_instr;

  logic [OW-1:0]   offset;
  logic [IW-1:0]   index;
  logic [TW-1:0]   tag;
  logic [IW-1:0]   req_idx;
  logic [TW-1:0]   req_tag;
  logic            hit;
  logic [31:0]     hit_word;
  logic            unused_pc_bits;

  assign offset   = PC[2 +: OW];
  assign index    = PC[2+OW +: IW];
  assign tag      = PC[2+OW+IW +: TW];
  assign req_idx  = req[IW-1:0];
  assign req_tag  = req[AW-1 -: TW];
  assign unused_pc_bits = ^{PC[31:10], PC[1:0]};

  assign hit      = valid[index] && (tag_arr[index] == tag);
  assign hit_word = data_arr[index][{offset, 5'd0} +: 32];

  // Reset is folded in so the stall drops the instant RESET falls, not at an edge.
  assign busywait    = RESET && ((state != S_IDLE) || !hit);
  assign INSTRUCTION = (state == S_IDLE && hit) ? hit_word : last_instr;
  assign mem_address = req;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= S_IDLE;
      valid      <= '0;
      req        <= '0;
      mem_read   <= 1'b0;
      last_instr <= '0;
      line_buf   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hit) begin
            last_instr <= hit_word;
          end else begin
            req      <= {tag, index};
            mem_read <= 1'b1;
            state    <= S_MEM_READ;
          end
        end
        S_MEM_READ: begin
          if (!mem_busywait) begin
            line_buf <= mem_readdata;
            mem_read <= 1'b0;
            state    <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          valid[req_idx] <= 1'b1;
          state          <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Data and tag need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge CLK) begin
    if (state == S_UPDATE) begin
      data_arr[req_idx] <= line_buf;
      tag_arr[req_idx]  <= req_tag;
    end
  end

endmodule

// File: tb/tb_instr_cache.sv
// Bench for instr_cache: directed vector table, reset/PC-wobble sequences,
// then random fetches checked against a block-residency model of the cache.
module tb_instr_cache;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  always #5 CLK = ~CLK;

  // Memory: stays busy for lat_cfg cycles after mem_read rises, garbage while busy.
  logic [127:0] mem_blk [64];
  int lat_cfg   = 0;
  int rd_cycles = 0;
  always @(posedge CLK) rd_cycles <= mem_read ? rd_cycles + 1 : 0;
  assign mem_busywait = mem_read && (rd_cycles < lat_cfg);
  assign mem_readdata = mem_busywait ? {4{32'hBAD0_BAD0}} : mem_blk[mem_address];

  instr_cache dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  typedef struct {
    logic [31:0] pc;
    int          lat;
    logic        miss;
    logic [5:0]  addr;
    logic [31:0] instr;
    int          stall;
  } vec_t;

  vec_t        vecs [9];
  int          errors = 0;
  int          checks = 0;
  int          resident [8];   // memory block held by each line, -1 when empty
  logic [31:0] last_hit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    logic [127:0] b;
    b = mem_blk[pc[9:4]];
    return b[int'(pc[3:2]) * 32 +: 32];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) resident[i] = -1;
    last_hit = 32'h0;
  endtask

  task automatic do_fetch(input logic [31:0] pc, input int lat, input logic exp_miss,
                          input logic [5:0] exp_addr, input logic [31:0] exp_instr,
                          input int exp_stall);
    int   cyc;
    int   rd;
    int   addr_bad;
    int   hold_bad;
    logic first_rd;
    @(negedge CLK);
    lat_cfg = lat;
    PC      = pc;
    #1;
    check("busy_now", busywait, exp_miss);
    if (!exp_miss) begin
      check("hit_instr", INSTRUCTION, exp_instr);
      last_hit = exp_instr;
      return;
    end
    check("hold_instr", INSTRUCTION, last_hit);
    cyc = 0; rd = 0; addr_bad = 0; hold_bad = 0; first_rd = 1'b0;
    // Stall cycles are counted from the edge that raises mem_read.
    do begin
      @(negedge CLK);
      if (busywait) begin
        if (cyc == 0) first_rd = mem_read;
        cyc++;
        if (mem_read) begin
          rd++;
          if (mem_address !== exp_addr) addr_bad++;
        end
        if (INSTRUCTION !== last_hit) hold_bad++;
      end
    end while (busywait && cyc < 60);
    check("read_rise", first_rd, 1);
    check("stall_cycles", cyc, exp_stall);
    check("read_cycles", rd, lat + 1);
    check("addr_errs", addr_bad, 0);
    check("hold_errs", hold_bad, 0);
    check("fill_instr", INSTRUCTION, exp_instr);
    check("read_low", mem_read, 0);
    resident[pc[6:4]] = int'(pc[9:4]);
    last_hit = exp_instr;
  endtask

  task automatic model_fetch(input logic [31:0] pc, input int lat);
    logic miss;
    miss = (resident[pc[6:4]] != int'(pc[9:4]));
    do_fetch(pc, lat, miss, pc[9:4], mem_word(pc), lat + 2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [31:0] rpc;
    RESET = 1'b0;
    PC    = 32'h0;
    clear_model();
    for (int b = 0; b < 64; b++) mem_blk[b] = {$urandom, $urandom, $urandom, $urandom};
    mem_blk[0]  = {32'h0000_0009, 32'h0002_0009, 32'h0004_0005, 32'h0000_0005};
    mem_blk[8]  = {32'h0000_8003, 32'h0000_8002, 32'h0000_8001, 32'h0000_8000};
    mem_blk[63] = {32'hF3F3_0003, 32'hF3F3_0002, 32'hF3F3_0001, 32'hF3F3_0000};

    vecs[0] = '{32'h0000_0000, 5, 1'b1, 6'h00, 32'h0000_0005, 7};
    vecs[1] = '{32'h0000_0004, 0, 1'b0, 6'h00, 32'h0004_0005, 0};
    vecs[2] = '{32'h0000_0008, 0, 1'b0, 6'h00, 32'h0002_0009, 0};
    vecs[3] = '{32'h0000_000C, 0, 1'b0, 6'h00, 32'h0000_0009, 0};
    vecs[4] = '{32'h0000_0080, 2, 1'b1, 6'h08, 32'h0000_8000, 4};
    vecs[5] = '{32'h0000_0000, 1, 1'b1, 6'h00, 32'h0000_0005, 3};
    vecs[6] = '{32'h0000_03F0, 0, 1'b1, 6'h3F, 32'hF3F3_0000, 2};
    vecs[7] = '{32'h0000_03FC, 0, 1'b0, 6'h00, 32'hF3F3_0003, 0};
    vecs[8] = '{32'hFFFF_F007, 0, 1'b0, 6'h00, 32'h0004_0005, 0};

    // Clock/reset.
    repeat (3) @(posedge CLK);
    #1;
    check("rst_mem_read", mem_read, 0);
    check("rst_busywait", busywait, 0);
    check("rst_instr", INSTRUCTION, 32'h0);
    check("rst_mem_addr", mem_address, 6'h00);
    RESET = 1'b1;

    for (int i = 0; i < 9; i++)
      do_fetch(vecs[i].pc, vecs[i].lat, vecs[i].miss, vecs[i].addr, vecs[i].instr, vecs[i].stall);

    // Asynchronous reset in the middle of a refill.
    @(negedge CLK);
    lat_cfg = 4;
    PC      = 32'h150;
    #1;
    check("mid_busy", busywait, 1);
    @(negedge CLK);
    check("mid_read_up", mem_read, 1);
    #2 RESET = 1'b0;
    #1;
    check("mid_rst_read", mem_read, 0);
    check("mid_rst_busy", busywait, 0);
    check("mid_rst_instr", INSTRUCTION, 32'h0);
    check("mid_rst_addr", mem_address, 6'h00);
    clear_model();
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    model_fetch(32'h150, 1);
    model_fetch(32'h000, 0);

    // PC moves during MEM_READ; the refill must stay on the latched line.
    @(negedge CLK);
    lat_cfg = 3;
    PC      = 32'h010;
    #1;
    check("wob_busy", busywait, 1);
    @(negedge CLK);
    check("wob_read", mem_read, 1);
    check("wob_addr0", mem_address, 6'h01);
    PC = 32'h020;
    @(negedge CLK);
    check("wob_addr1", mem_address, 6'h01);
    PC = 32'h010;
    w = 0;
    while (busywait && w < 20) begin
      @(negedge CLK);
      if (mem_read && mem_address !== 6'h01) check("wob_addr_n", mem_address, 6'h01);
      w++;
    end
    check("wob_done", busywait, 0);
    check("wob_instr", INSTRUCTION, mem_word(32'h010));
    resident[1] = 1;
    last_hit    = mem_word(32'h010);
    model_fetch(32'h020, 0);
    model_fetch(32'h014, 0);

    // Random fetches over 16 blocks competing for 8 lines, junk in ignored PC bits.
    for (int i = 0; i < 80; i++) begin
      rpc      = $urandom;
      rpc[9:7] = 3'($urandom_range(0, 1));
      model_fetch(rpc, $urandom_range(0, 4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
